// File: rtl/cavlc_run_before.sv
// cavlc_run_before: walks one captured 4x4 coefficient block from the highest
// nonzero position downwards and emits one run_before symbol per coded
// coefficient. It stops when the zero budget is spent or the scan runs off
// position 0.
module cavlc_run_before (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [239:0] coef_blk,
  input  logic [3:0]   total_zeros_in,
  output logic         busy,
  output logic         run_valid,
  input  logic         run_ready,
  output logic [3:0]   run_before,
  output logic [3:0]   zeros_left,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [239:0] r_coef;
  logic [3:0]   r_zl;
  logic [3:0]   r_run;
  logic [3:0]   r_ptr;

  logic [15:0]       w_in_nz;
  logic [15:0]       w_reg_nz;
  logic [3:0]        w_hi_pos;
  logic              w_any_nz;
  logic signed [4:0] w_q;
  logic              w_q_below;
  logic [3:0]        w_zl_next;

  // Per-position nonzero flags for the live input and for the captured block.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_in_nz[k]  = (coef_blk[15*k +: 15] != 15'd0);
      w_reg_nz[k] = (r_coef[15*k +: 15] != 15'd0);
    end
  end

  // Highest nonzero position of the input block; the ascending loop lets the
  // highest hit win.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_hi_pos = 4'd0;
    w_any_nz = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (w_in_nz[k]) begin
        w_hi_pos = 4'(k);
        w_any_nz = 1'b1;
      end
    end
  end

  // The scan position q is always ptr-1-run. It is kept 5 bits signed so
  // that position 0 and "below 0" stay distinct. In EMIT it still points at
  // the nonzero coefficient that ends the current run.
  assign w_q       = $signed({1'b0, r_ptr}) - $signed({1'b0, r_run}) - 5'sd1;
  assign w_q_below = w_q[4];

  // Remaining zeros after this symbol, saturating at 0 for inconsistent input.
  assign w_zl_next = (r_zl > r_run) ? (r_zl - r_run) : 4'd0;

  // Control FSM and datapath registers. A synchronous reset overrides
  // everything else, including a pending symbol.
  // NOTE: state registers use non-blocking assignments only. All flops update
  // together from the pre-edge values, which is what the w_q arithmetic relies
  // on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_coef  <= '0;
      r_zl    <= '0;
      r_run   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_coef <= coef_blk;
            r_zl   <= total_zeros_in;
            r_run  <= '0;
            r_ptr  <= w_hi_pos;
            if (!w_any_nz || (total_zeros_in == 4'd0)) r_state <= S_DONE;
            else                                       r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_q_below)                 r_state <= S_DONE;
          else if (!w_reg_nz[w_q[3:0]]) r_run   <= r_run + 4'd1;
          else                           r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (run_ready) begin
            r_zl    <= w_zl_next;
            r_ptr   <= w_q[3:0];
            r_run   <= '0;
            r_state <= (w_zl_next == 4'd0) ? S_DONE : S_SCAN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state. The symbol fields are
  // forced to 0 whenever no symbol is presented.
  assign busy       = (r_state != S_IDLE);
  assign run_valid  = (r_state == S_EMIT);
  assign run_before = run_valid ? r_run : 4'd0;
  assign zeros_left = run_valid ? r_zl  : 4'd0;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_cavlc_run_before.sv
// Directed bench for cavlc_run_before: a table of blocks with hand-computed
// symbol sequences and busy lengths, plus backpressure and mid-EMIT reset
// sequences.
module tb_cavlc_run_before;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [239:0] coef_blk;
  logic [3:0]   total_zeros_in;
  logic         busy;
  logic         run_valid;
  logic         run_ready;
  logic [3:0]   run_before;
  logic [3:0]   zeros_left;
  logic         done;

  cavlc_run_before dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .coef_blk       (coef_blk),
    .total_zeros_in (total_zeros_in),
    .busy           (busy),
    .run_valid      (run_valid),
    .run_ready      (run_ready),
    .run_before     (run_before),
    .zeros_left     (zeros_left),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string          name;
    logic [239:0]   coef;
    logic [3:0]     tz;
    int             n_sym;
    logic [2:0][7:0] sym;      // {run_before, zeros_left}
    int             busy_cyc;
  } vec_t;

  localparam int NV = 10;
  vec_t         vecs [NV];
  logic [239:0] junk;
  logic [7:0]   obs [$];

  function automatic logic [239:0] put(input logic [239:0] b, input int pos, input logic [14:0] v);
    logic [239:0] r;
    r = b;
    r[15*pos +: 15] = v;
    return r;
  endfunction

  task automatic set_vec(input int i, input string name, input logic [239:0] c,
                         input logic [3:0] tz, input int n, input logic [7:0] s0,
                         input logic [7:0] s1, input int bc);
    vecs[i].name     = name;
    vecs[i].coef     = c;
    vecs[i].tz       = tz;
    vecs[i].n_sym    = n;
    vecs[i].sym      = {8'h00, s1, s0};
    vecs[i].busy_cyc = bc;
  endtask

  // Runs one block with run_ready as currently driven. start is held high
  // with junk data while busy, to show it is ignored.
  task automatic run_vec(input int i);
    int busy_cnt = 0;
    int done_cnt = 0;
    int viol     = 0;
    int cyc      = 0;
    bit fin      = 0;
    obs.delete();
    @(posedge clk); #1;
    start          = 1'b1;
    coef_blk       = vecs[i].coef;
    total_zeros_in = vecs[i].tz;
    @(posedge clk); #1;
    coef_blk       = junk;
    total_zeros_in = 4'hF;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      else      fin = 1;
      if (run_valid && run_ready) obs.push_back({run_before, zeros_left});
      if (!run_valid && (run_before != 4'd0 || zeros_left != 4'd0)) viol++;
      if (done) begin
        done_cnt++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({vecs[i].name, " finished"}, 32'(fin), 32'd1);
    check({vecs[i].name, " busy cycles"}, busy_cnt, vecs[i].busy_cyc);
    check({vecs[i].name, " done pulses"}, done_cnt, 1);
    check({vecs[i].name, " symbol count"}, obs.size(), vecs[i].n_sym);
    check({vecs[i].name, " idle fields nonzero"}, viol, 0);
    for (int j = 0; j < vecs[i].n_sym; j++)
      check({vecs[i].name, $sformatf(" symbol %0d", j)},
            (j < obs.size()) ? 32'(obs[j]) : 32'hFFFF_FFFF, 32'(vecs[i].sym[j]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [239:0] c;
    int cyc;

    junk = '0;
    for (int k = 0; k < 16; k++) junk = put(junk, k, 15'h0001);

    c = put(put(put('0, 0, 15'h0001), 2, 15'h7FFD), 5, 15'h0005);
    set_vec(0, "basic", c, 4'd3, 2, 8'h23, 8'h11, 8);
    set_vec(1, "all_zero", '0, 4'd5, 0, 8'h00, 8'h00, 1);
    set_vec(2, "single7", put('0, 7, 15'h0002), 4'd7, 0, 8'h00, 8'h00, 9);
    c = put(put(put('0, 15, 15'h0003), 1, 15'h7FFF), 0, 15'h0001);
    set_vec(3, "long_run", c, 4'd13, 1, 8'hDD, 8'h00, 16);
    set_vec(4, "tz_zero", put(put('0, 5, 15'h1), 2, 15'h1), 4'd0, 0, 8'h00, 8'h00, 1);
    set_vec(5, "tz_short", put(put('0, 3, 15'h9), 0, 15'h9), 4'd1, 1, 8'h21, 8'h00, 5);
    c = put(put(put('0, 4, 15'h1), 3, 15'h1), 1, 15'h1);
    set_vec(6, "adjacent", c, 4'd1, 2, 8'h01, 8'h11, 6);
    set_vec(7, "msb_only", put(put('0, 2, 15'h4000), 0, 15'h7FFF), 4'd1, 1, 8'h11, 8'h00, 4);
    set_vec(8, "tz_large", put('0, 3, 15'h1), 4'd5, 0, 8'h00, 8'h00, 5);
    set_vec(9, "top_only", put('0, 15, 15'h1), 4'd15, 0, 8'h00, 8'h00, 17);

    // Reset state
    rst = 1'b1; start = 1'b0; run_ready = 1'b1; coef_blk = '0; total_zeros_in = '0;
    repeat (2) @(negedge clk);
    check("outputs in reset", {busy, run_valid, run_before, zeros_left, done}, 11'd0);
    rst = 1'b0;
    @(negedge clk);
    check("outputs after reset", {busy, run_valid, run_before, zeros_left, done}, 11'd0);

    // Table of directed blocks
    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure on the first symbol of the basic block
    run_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; coef_blk = vecs[0].coef; total_zeros_in = vecs[0].tz;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!run_valid && cyc < 20);
    check("bp reached emit", 32'(run_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold %0d", k), {run_valid, run_before, zeros_left}, 9'h123);
      if (k < 4) @(negedge clk);
    end
    run_ready = 1'b1;
    obs.delete();
    obs.push_back({run_before, zeros_left});
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (run_valid && run_ready) obs.push_back({run_before, zeros_left});
    end
    check("bp symbols accepted", obs.size(), 2);
    check("bp second symbol", (obs.size() > 1) ? 32'(obs[1]) : 32'hFFFF_FFFF, 32'h11);
    check("bp idle at end", 32'(busy), 32'd0);

    // Reset while a symbol is pending
    run_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; coef_blk = vecs[0].coef; total_zeros_in = vecs[0].tz;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!run_valid && cyc < 20);
    check("rst reached emit", 32'(run_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("outputs after mid-emit reset", {busy, run_valid, run_before, zeros_left, done}, 11'd0);
    rst = 1'b0;
    run_ready = 1'b1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done || run_valid) cyc++;
    end
    check("no activity after reset", cyc, 0);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
